// File: rtl/pip_stall_ctrl_pkg.sv
// Shared operand-timing encodings and scoreboard types for the hazard/stall controller.
// The decoder produces tuse/tnew with the same constants.
package pip_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    TUSE_D    = 2'd0,
    TUSE_E    = 2'd1,
    TUSE_M    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  typedef enum logic [1:0] {
    TNEW_NONE = 2'd0,
    TNEW_ALU  = 2'd1,
    TNEW_LOAD = 2'd2
  } tnew_e;

  localparam int unsigned LAT_MULT_DEFAULT = 5;
  localparam int unsigned LAT_DIV_DEFAULT  = 10;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
  } sb_entry_t;

  // A source is blocked when an older producer writes it and is not forwardable in time.
  function automatic logic src_hazard(input sb_entry_t ent, input logic [4:0] src,
                                      input logic [1:0] tuse);
    return (ent.wa != 5'd0) && (ent.wa == src) && (ent.tnew > tuse);
  endfunction

  function automatic logic [1:0] tnew_age(input logic [1:0] tnew);
    return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 2'd1;
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Mult/div busy counter: loads a latency, counts down to zero and saturates there.
module md_busy_cnt #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          busy
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/pip_stall_ctrl.sv
// Hazard/stall controller: compares D-stage operands against the E/M scoreboard and the
// mult/div busy state, and drives PC/F-D enables and the D/E bubble clear.
module pip_stall_ctrl
  import pip_stall_ctrl_pkg::*;
#(
  parameter int unsigned LAT_MULT = LAT_MULT_DEFAULT,
  parameter int unsigned LAT_DIV  = LAT_DIV_DEFAULT,
  parameter int unsigned CW       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_wa,
  input  logic [1:0] d_tnew,
  input  logic       d_md_start,
  input  logic       d_md_div,
  input  logic       d_md_use,
  output logic       pc_en,
  output logic       fd_en,
  output logic       de_clr,
  output logic       md_busy,
  output logic       stall
);

  sb_entry_t e_q, e_d;
  sb_entry_t m_q, m_d;

  logic          e_haz, m_haz, md_haz;
  logic          md_load;
  logic [CW-1:0] md_load_val;

  assign e_haz  = src_hazard(e_q, d_rs, d_tuse_rs) | src_hazard(e_q, d_rt, d_tuse_rt);
  assign m_haz  = src_hazard(m_q, d_rs, d_tuse_rs) | src_hazard(m_q, d_rt, d_tuse_rt);
  assign md_haz = d_md_use & md_busy;

  assign stall  = e_haz | m_haz | md_haz;
  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall;

  // A start held in D by a stall must not load; it loads on the cycle it really issues.
  assign md_load     = ~stall & d_md_start;
  assign md_load_val = d_md_div ? CW'(LAT_DIV) : CW'(LAT_MULT);

  always_comb begin
    m_d.wa   = e_q.wa;
    m_d.tnew = tnew_age(e_q.tnew);
    if (stall) begin
      e_d.wa   = 5'd0;
      e_d.tnew = TNEW_NONE;
    end else begin
      e_d.wa   = d_wa;
      e_d.tnew = d_tnew;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
    end
  end

  md_busy_cnt #(
    .CW (CW)
  ) u_md_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .load_val (md_load_val),
    .busy     (md_busy)
  );

endmodule

// File: tb/tb_pip_stall_ctrl.sv
// Directed vector table plus randomized traffic against an issue-history reference model.
module tb_pip_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_md_start, d_md_div, d_md_use;
  logic       pc_en, fd_en, de_clr, md_busy, stall;

  int checks   = 0;
  int failures = 0;

  pip_stall_ctrl #(
    .LAT_MULT (5),
    .LAT_DIV  (10),
    .CW       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_wa       (d_wa),
    .d_tnew     (d_tnew),
    .d_md_start (d_md_start),
    .d_md_div   (d_md_div),
    .d_md_use   (d_md_use),
    .pc_en      (pc_en),
    .fd_en      (fd_en),
    .de_clr     (de_clr),
    .md_busy    (md_busy),
    .stall      (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         rst;
    bit         chk;
    logic [4:0] rs;
    logic [1:0] trs;
    logic [4:0] rt;
    logic [1:0] trt;
    logic [4:0] wa;
    logic [1:0] tn;
    bit         ms;
    bit         md;
    bit         mu;
    bit         es;
    bit         eb;
  } vec_t;

  vec_t tbl[$];

  // Reference model: what was issued in the last two cycles, plus the last mult/div issue time.
  logic [4:0] h_wa[2];
  logic [1:0] h_tn[2];
  bit         md_valid;
  int         md_issue;
  int         md_lat;
  int         cyc;

  function automatic bit src_blocked(input logic [4:0] src, input logic [1:0] tuse);
    bit blk;
    int rem;
    blk = 1'b0;
    for (int age = 1; age <= 2; age++) begin
      // Producer issued 'age' cycles ago has consumed (age-1) of its tnew cycles.
      rem = int'(h_tn[age-1]) - (age - 1);
      if (rem < 0) rem = 0;
      if (h_wa[age-1] != 5'd0 && h_wa[age-1] == src && rem > int'(tuse)) blk = 1'b1;
    end
    return blk;
  endfunction

  function automatic bit model_busy();
    return md_valid && (cyc - md_issue) <= md_lat;
  endfunction

  function automatic bit model_stall();
    return src_blocked(d_rs, d_tuse_rs) | src_blocked(d_rt, d_tuse_rt) |
           (d_md_use && model_busy());
  endfunction

  task automatic model_clear();
    h_wa[0]  = '0;
    h_wa[1]  = '0;
    h_tn[0]  = '0;
    h_tn[1]  = '0;
    md_valid = 1'b0;
    md_issue = 0;
    md_lat   = 0;
  endtask

  task automatic add(input bit rst, input bit chk, input logic [4:0] rs, input logic [1:0] trs,
                     input logic [4:0] rt, input logic [1:0] trt, input logic [4:0] wa,
                     input logic [1:0] tn, input bit ms, input bit md, input bit mu,
                     input bit es, input bit eb);
    vec_t v;
    v = '{rst, chk, rs, trs, rt, trt, wa, tn, ms, md, mu, es, eb};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset      = v.rst;
    d_rs       = v.rs;
    d_tuse_rs  = v.trs;
    d_rt       = v.rt;
    d_tuse_rt  = v.trt;
    d_wa       = v.wa;
    d_tnew     = v.tn;
    d_md_start = v.ms;
    d_md_div   = v.md;
    d_md_use   = v.mu;
  endtask

  // One D cycle: check at negedge, then advance model at posedge.
  task automatic do_cycle(input bit chk, input bit use_tbl, input bit es, input bit eb,
                          input string nm);
    bit         ms_, mb_, want_s, want_b;
    logic [4:0] act, want;
    @(negedge clk);
    ms_    = model_stall();
    mb_    = model_busy();
    want_s = use_tbl ? es : ms_;
    want_b = use_tbl ? eb : mb_;
    if (chk) begin
      checks++;
      act  = {stall, pc_en, fd_en, de_clr, md_busy};
      want = {want_s, ~want_s, ~want_s, want_s, want_b};
      if (act !== want) begin
        failures++;
        $display("FAIL %s: stall/pc_en/fd_en/de_clr/md_busy got %b want %b", nm, act, want);
      end
    end
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      h_wa[1] = h_wa[0];
      h_tn[1] = h_tn[0];
      h_wa[0] = ms_ ? 5'd0 : d_wa;
      h_tn[0] = ms_ ? 2'd0 : d_tnew;
      if (!ms_ && d_md_start) begin
        md_valid = 1'b1;
        md_issue = cyc;
        md_lat   = d_md_div ? 10 : 5;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic nop(input bit eb);
    add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, eb);
  endtask

  initial begin
    cyc = 0;
    model_clear();

    // Reset, then a plain read
    add(1, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs; the stalled addu $12 must enter E as a bubble
    add(0, 1, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0, 0);
    add(0, 1, 8, 1, 0, 3, 12, 1, 0, 0, 0, 1, 0);
    add(0, 1, 8, 1, 12, 0, 12, 1, 0, 0, 0, 0, 0);
    nop(0);
    // Branch after load: two stalls
    add(0, 1, 0, 3, 0, 3, 9, 2, 0, 0, 0, 0, 0);
    add(0, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    // Branch after ALU: one stall
    add(0, 1, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0, 0);
    add(0, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    // $0 never hazards
    add(0, 1, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rt
    add(0, 1, 0, 3, 0, 3, 3, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 3, 3, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    // div then mflo: 10 stalls
    add(0, 1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1, 1);
    add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    // mult then mflo: 5 stalls
    add(0, 1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 1, 1);
    add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    // div, busy exactly 10 cycles, mflo 12 cycles later does not stall
    add(0, 1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 10; k++) nop(1);
    nop(0);
    add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    // mult stalled by a load: no counter load until it issues; then reset mid-busy
    add(0, 1, 0, 3, 0, 3, 4, 2, 0, 0, 0, 0, 0);
    add(0, 1, 4, 1, 0, 3, 0, 0, 1, 0, 1, 1, 0);
    add(0, 1, 4, 1, 0, 3, 0, 0, 1, 0, 1, 0, 0);
    nop(1);
    add(1, 1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, 0);
    // Reset mid-stall clears the scoreboard
    add(0, 1, 0, 3, 0, 3, 7, 2, 0, 0, 0, 0, 0);
    add(1, 1, 7, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    // E and M hazards together
    add(0, 1, 0, 3, 0, 3, 10, 2, 0, 0, 0, 0, 0);
    add(0, 1, 0, 3, 0, 3, 11, 2, 0, 0, 0, 0, 0);
    add(0, 1, 10, 0, 11, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 10, 0, 11, 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 10, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i]);
      do_cycle(tbl[i].chk, 1'b1, tbl[i].es, tbl[i].eb, $sformatf("vec%0d", i));
    end

    for (int n = 0; n < 800; n++) begin
      reset      = ($urandom_range(0, 59) == 0);
      d_rs       = 5'($urandom_range(0, 7));
      d_rt       = 5'($urandom_range(0, 7));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_wa       = 5'($urandom_range(0, 7));
      d_tnew     = 2'($urandom_range(0, 2));
      d_md_start = ($urandom_range(0, 11) == 0);
      d_md_div   = 1'($urandom_range(0, 1));
      d_md_use   = d_md_start | ($urandom_range(0, 3) == 0);
      do_cycle(1'b1, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
